// File: rtl/bp_pkg.sv
// ============================================================================
// Module      : bp_pkg
// Description : Shared types for the branch-predictor update scheduler.
//               Chooser and scheduler state encodings, plus the update record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    // Default geometry of the update record.
    localparam int BP_PC_W      = 32;
    localparam int BP_GHR_W     = 8;
    localparam int BP_FLAGS_W   = 3;

    // Tournament chooser 2-bit saturating states.
    typedef enum logic [1:0] {
        STRONG_LOCAL  = 2'd0,
        WEAK_LOCAL    = 2'd1,
        WEAK_GLOBAL   = 2'd2,
        STRONG_GLOBAL = 2'd3
    } chooser_state_e;

    // Update scheduler states.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_STARVED = 2'd2
    } sched_state_e;

    // Update record at default widths; the top packs the same field order
    // into a flat vector so that non-default PC_W/GHR_W still work.
    typedef struct packed {
        logic [BP_PC_W-1:0]  pc;
        logic [BP_GHR_W-1:0] ghr;
        logic                taken;
        logic                local_pred;
        logic                global_pred;
    } upd_entry_t;

    // Width of one packed update record.
    function automatic int entry_width(input int pc_w, input int ghr_w);
        return pc_w + ghr_w + BP_FLAGS_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_update_scheduler_if.sv
// ============================================================================
// Module      : bp_update_scheduler_if
// Description : Resolve/lookup/update bundle between execute, fetch and the
//               predictor tables. slave = scheduler side, master = environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bp_update_scheduler_if #(
    parameter int PC_W  = 32,
    parameter int GHR_W = 8,
    parameter int DEPTH = 4
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             res_valid;
    logic             res_ready;
    logic [PC_W-1:0]  res_pc;
    logic             res_taken;
    logic             res_local_pred;
    logic             res_global_pred;
    logic [GHR_W-1:0] res_ghr;
    logic             lookup_busy;
    logic             fetch_stall;
    logic             upd_en;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic [GHR_W-1:0] upd_ghr;
    logic             sel_upd_en;
    logic             sel_outcome;
    logic [CNT_W-1:0] pending;

    modport slave (
        input  res_valid, res_pc, res_taken, res_local_pred, res_global_pred,
               res_ghr, lookup_busy,
        output res_ready, fetch_stall, upd_en, upd_pc, upd_taken, upd_ghr,
               sel_upd_en, sel_outcome, pending
    );

    modport master (
        output res_valid, res_pc, res_taken, res_local_pred, res_global_pred,
               res_ghr, lookup_busy,
        input  res_ready, fetch_stall, upd_en, upd_pc, upd_taken, upd_ghr,
               sel_upd_en, sel_outcome, pending
    );
endinterface

`default_nettype wire

// File: rtl/bp_update_fifo.sv
// ============================================================================
// Module      : bp_update_fifo
// Description : DEPTH-entry synchronous FIFO (power-of-two depth) with
//               occupancy count. Push when full / pop when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 43
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_data,
    input  wire logic                       i_pop,
    output logic [WIDTH-1:0]                o_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [$clog2(DEPTH):0]          o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/bp_update_scheduler.sv
// ============================================================================
// Module      : bp_update_scheduler
// Description : Buffers resolved branches and drains them into the single-
//               ported predictor tables whenever fetch leaves the ports free.
//               Drives chooser training strobes and a starvation fetch stall.
//               Optional macro BP_UPD_BYPASS_EN: issue straight from the input
//               when the FIFO is empty and the ports are free.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int PC_W       = 32,
    parameter int GHR_W      = 8,
    parameter int STARVE_MAX = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    bp_update_scheduler_if.slave    bus
);
    localparam int ENTRY_W = entry_width(PC_W, GHR_W);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int STV_W   = $clog2(STARVE_MAX) + 1;

    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] w_src;
    logic               w_issue;
    logic               w_bypass;
    logic               w_push;
    logic               w_fire;
    logic               w_last_pop;

    sched_state_e       r_state;
    logic [STV_W-1:0]   r_starve_cnt;
    logic               r_fetch_stall;
    logic               r_upd_en;
    logic [PC_W-1:0]    r_upd_pc;
    logic               r_upd_taken;
    logic [GHR_W-1:0]   r_upd_ghr;
    logic               r_sel_upd_en;
    logic               r_sel_outcome;

    // Record layout matches upd_entry_t: {pc, ghr, taken, local, global}.
    assign w_in_entry = {bus.res_pc, bus.res_ghr, bus.res_taken,
                         bus.res_local_pred, bus.res_global_pred};

`ifdef BP_UPD_BYPASS_EN
    assign w_bypass = w_empty && bus.res_valid && !bus.lookup_busy;
`else
    assign w_bypass = 1'b0;
`endif

    // Fetch owns the ports; a queued update only goes out on a free cycle.
    assign w_issue    = !w_empty && !bus.lookup_busy;
    assign w_push     = bus.res_valid && !w_full && !w_bypass;
    assign w_fire     = w_issue || w_bypass;
    assign w_src      = w_issue ? w_head : w_in_entry;
    assign w_last_pop = w_issue && (w_count == CNT_W'(1)) && !w_push;

    bp_update_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_in_entry),
        .i_pop   (w_issue),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Registered one-cycle table write and chooser training strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_en      <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_taken   <= 1'b0;
            r_upd_ghr     <= '0;
            r_sel_upd_en  <= 1'b0;
            r_sel_outcome <= 1'b0;
        end else begin
            r_upd_en      <= w_fire;
            r_upd_pc      <= w_fire ? w_src[ENTRY_W-1 -: PC_W] : '0;
            r_upd_ghr     <= w_fire ? w_src[GHR_W+2:3] : '0;
            r_upd_taken   <= w_fire && w_src[2];
            // Chooser learns only from local/global disagreement.
            r_sel_upd_en  <= w_fire && (w_src[1] != w_src[0]);
            r_sel_outcome <= w_fire && (w_src[0] == w_src[2]);
        end
    end

    // Scheduler FSM: tracks blocked cycles and raises fetch_stall on starvation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_starve_cnt  <= '0;
            r_fetch_stall <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_starve_cnt  <= '0;
                    r_fetch_stall <= 1'b0;
                    if (w_push) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_issue) begin
                        r_starve_cnt <= '0;
                        if (w_last_pop) r_state <= S_IDLE;
                    end else if (!w_empty) begin
                        // Counter saturates at STARVE_MAX-1; that blocked cycle escalates.
                        if (r_starve_cnt == STV_W'(STARVE_MAX - 1)) begin
                            r_state       <= S_STARVED;
                            r_fetch_stall <= 1'b1;
                        end else begin
                            r_starve_cnt <= r_starve_cnt + STV_W'(1);
                        end
                    end
                end
                S_STARVED: begin
                    if (w_issue) begin
                        r_starve_cnt  <= '0;
                        r_fetch_stall <= 1'b0;
                        r_state       <= w_last_pop ? S_IDLE : S_DRAIN;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_starve_cnt  <= '0;
                    r_fetch_stall <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res_ready   = !w_full;
    assign bus.pending     = w_count;
    assign bus.fetch_stall = r_fetch_stall;
    assign bus.upd_en      = r_upd_en;
    assign bus.upd_pc      = r_upd_pc;
    assign bus.upd_taken   = r_upd_taken;
    assign bus.upd_ghr     = r_upd_ghr;
    assign bus.sel_upd_en  = r_sel_upd_en;
    assign bus.sel_outcome = r_sel_outcome;

endmodule

`default_nettype wire
